srlzr_tx_sched: RTL and testbench

// - Round-robin scheduler that shares one PISO serializer (LSB-first shift register) among NUM_REQ requesters.
// - Accepts a parallel word from the winning requester and sequences the serializer: one load cycle, then DATA_WIDTH shift cycles.
// - Frames the serial stream: optional parity bit, then a fixed idle gap.
// - Sits between the transmit-side word sources and the serializer in the Transceiver path.
//

---
 rtl/srlzr_tx_sched.sv | 135 +++++++++++++
 tb/tb_srlzr_tx_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/srlzr_tx_sched.sv
// Round-robin scheduler feeding one shared LSB-first PISO serializer; SRLZR_TX_PARITY_EN adds an even-parity bit.
// Latency: handshake T, srl_load T+1, data bits T+2..T+1+DATA_WIDTH, then optional parity and GAP_CYCLES idle-high.
// Backpressure: req_ready is offered only in IDLE, so requests arriving while busy wait and are never dropped.
module srlzr_tx_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         srl_data,
    output logic                          srl_load,
    output logic                          srl_shift,
    input  logic                          srl_bit,
    output logic                          tx_out,
    output logic                          tx_en,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          frame_done
);
    localparam int CNT_MAX  = (DATA_WIDTH > GAP_CYCLES) ? DATA_WIDTH : GAP_CYCLES;
    localparam int CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd4;
`ifdef SRLZR_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    // Where a frame goes once its last bit is out: GAP, or straight back to IDLE when there is no gap.
    localparam logic [2:0] ST_POST   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    logic [2:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [CW-1:0]   cnt;
    logic [ID_W-1:0] win;
    logic            found;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == ST_IDLE) && found && (win == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            srl_data   <= '0;
            grant_id   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        srl_data <= req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                        grant_id <= win;
                        rr_ptr   <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt == CW'(DATA_WIDTH - 1)) begin
                        cnt <= '0;
`ifdef SRLZR_TX_PARITY_EN
                        state <= ST_PARITY;
`else
                        frame_done <= 1'b1;
                        state      <= ST_POST;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SRLZR_TX_PARITY_EN
                ST_PARITY: begin
                    frame_done <= 1'b1;
                    state      <= ST_POST;
                end
`endif
                ST_GAP: begin
                    if (cnt == CW'(GAP_LAST)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign srl_load  = (state == ST_LOAD);
    assign srl_shift = (state == ST_SHIFT);
    assign busy      = (state != ST_IDLE);
`ifdef SRLZR_TX_PARITY_EN
    assign tx_en  = (state == ST_SHIFT) || (state == ST_PARITY);
    assign tx_out = (state == ST_SHIFT)  ? srl_bit :
                    (state == ST_PARITY) ? ^srl_data : 1'b1;
`else
    assign tx_en  = (state == ST_SHIFT);
    assign tx_out = (state == ST_SHIFT) ? srl_bit : 1'b1;
`endif

endmodule

// File: tb/tb_srlzr_tx_sched.sv
// Directed bench for srlzr_tx_sched: main instance with defaults, second instance with GAP_CYCLES=0.
module tb_srlzr_tx_sched;
    localparam int DW = 8;
    localparam int NR = 4;
`ifdef SRLZR_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_data  = '0;
    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    srl_data;
    logic             srl_load, srl_shift, srl_bit, tx_out, tx_en, busy, frame_done;
    logic [1:0]       grant_id;

    logic [NR-1:0]    req_valid_g = '0;
    logic [NR*DW-1:0] req_data_g  = '0;
    logic [NR-1:0]    req_ready_g;
    logic [DW-1:0]    srl_data_g;
    logic             srl_load_g, srl_shift_g, srl_bit_g, tx_out_g, tx_en_g, busy_g, frame_done_g;
    logic [1:0]       grant_id_g;

    srlzr_tx_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .srl_data(srl_data), .srl_load(srl_load), .srl_shift(srl_shift), .srl_bit(srl_bit),
        .tx_out(tx_out), .tx_en(tx_en), .grant_id(grant_id), .busy(busy), .frame_done(frame_done));

    srlzr_tx_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst(rst), .req_valid(req_valid_g), .req_data(req_data_g), .req_ready(req_ready_g),
        .srl_data(srl_data_g), .srl_load(srl_load_g), .srl_shift(srl_shift_g), .srl_bit(srl_bit_g),
        .tx_out(tx_out_g), .tx_en(tx_en_g), .grant_id(grant_id_g), .busy(busy_g), .frame_done(frame_done_g));

    // External PISO serializers driven by each scheduler.
    logic [DW-1:0] sreg = '0, sreg_g = '0;
    always @(posedge clk) begin
        if (srl_load) sreg <= srl_data;
        else if (srl_shift) sreg <= sreg >> 1;
        if (srl_load_g) sreg_g <= srl_data_g;
        else if (srl_shift_g) sreg_g <= sreg_g >> 1;
    end
    assign srl_bit   = sreg[0];
    assign srl_bit_g = sreg_g[0];

    int passes = 0;
    int fails  = 0;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (busy && n < 60) begin step(); n++; end
        if (busy) begin fails++; $display("FAIL wait_idle: busy=%b after %0d cycles, need 0", busy, n); end else passes++;
    endtask

    // Handshake requester r with word w, scramble its data afterwards, collect the data bits.
    task automatic send_collect(input int r, input logic [DW-1:0] w,
                                output logic [DW-1:0] bits, output logic [DW-1:0] cap, output logic ld);
        req_data[r*DW +: DW] = w;
        req_valid = '0;
        req_valid[r] = 1'b1;
        step();
        req_valid = '0;
        req_data[r*DW +: DW] = ~w;
        ld  = srl_load;
        cap = srl_data;
        step();
        for (int i = 0; i < DW; i++) begin
            bits[i] = tx_out;
            step();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0;
        step(); step();
        if ({req_ready, srl_load, srl_shift, srl_data, tx_out, tx_en, grant_id, busy, frame_done}
            !== {4'b0000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset_outputs: ready=%b load=%b shift=%b data=%h tx=%b en=%b gid=%0d busy=%b done=%b",
                              req_ready, srl_load, srl_shift, srl_data, tx_out, tx_en, grant_id, busy, frame_done);
        end else passes++;
        if ({tx_out_g, busy_g, frame_done_g} !== 3'b100) begin
            fails++; $display("FAIL reset_g0: tx=%b busy=%b done=%b need 1 0 0", tx_out_g, busy_g, frame_done_g);
        end else passes++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_frame;
        logic [DW-1:0] w;
        w = 8'hA5;
        req_data[7:0] = w;
        req_valid = 4'b0001;
        #1;
        if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready: %b need 0001", req_ready); end else passes++;
        step();
        req_valid = '0;
        if (srl_load !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL single_load: load=%b busy=%b need 1 1", srl_load, busy); end else passes++;
        if (srl_data !== w || grant_id !== 2'd0) begin fails++; $display("FAIL single_capture: data=%h gid=%0d need a5 0", srl_data, grant_id); end else passes++;
        step();
        for (int i = 0; i < DW; i++) begin
            if (tx_out !== w[i] || tx_en !== 1'b1 || srl_shift !== 1'b1)
                begin fails++; $display("FAIL single_bit%0d: tx=%b en=%b shift=%b need %b 1 1", i, tx_out, tx_en, srl_shift, w[i]); end
            else passes++;
            step();
        end
        if (PAR == 1) begin
            if (tx_out !== ^w || tx_en !== 1'b1 || frame_done !== 1'b0)
                begin fails++; $display("FAIL single_parity: tx=%b en=%b done=%b need %b 1 0", tx_out, tx_en, frame_done, ^w); end
            else passes++;
            step();
        end
        if (frame_done !== 1'b1 || tx_out !== 1'b1 || tx_en !== 1'b0)
            begin fails++; $display("FAIL single_done: done=%b tx=%b en=%b need 1 1 0", frame_done, tx_out, tx_en); end
        else passes++;
        step();
        if (frame_done !== 1'b0 || busy !== 1'b1 || tx_out !== 1'b1)
            begin fails++; $display("FAIL single_gap2: done=%b busy=%b tx=%b need 0 1 1", frame_done, busy, tx_out); end
        else passes++;
        step();
        if (busy !== 1'b0) begin fails++; $display("FAIL single_idle: busy=%b need 0", busy); end else passes++;
    endtask

    task automatic test_round_robin;
        logic [DW-1:0] wv [4];
        int n;
        wv = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst = 1'b1; step(); rst = 1'b0;
        req_data  = {wv[3], wv[2], wv[1], wv[0]};
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!srl_load && n < 40) begin step(); n++; end
            if (!srl_load) begin fails++; $display("FAIL rr_timeout: frame %0d no srl_load", k); break; end
            if (grant_id !== 2'(k % 4) || srl_data !== wv[k % 4])
                begin fails++; $display("FAIL rr_grant%0d: gid=%0d data=%h need %0d %h", k, grant_id, srl_data, k % 4, wv[k % 4]); end
            else passes++;
            step();
        end
        req_valid = '0;
        wait_idle();
    endtask

    task automatic test_parity;
        logic [DW-1:0] ws [2];
        logic [DW-1:0] bits, cap;
        logic ld, pexp;
        ws = '{8'h07, 8'h03};
        for (int k = 0; k < 2; k++) begin
            wait_idle();
            pexp = (k == 0) ? 1'b1 : 1'b0;
            send_collect(0, ws[k], bits, cap, ld);
            if (bits !== ws[k]) begin fails++; $display("FAIL parity_data%0d: %h need %h", k, bits, ws[k]); end else passes++;
            if (PAR == 1) begin
                if (tx_out !== pexp || tx_en !== 1'b1 || frame_done !== 1'b0)
                    begin fails++; $display("FAIL parity_bit%0d: tx=%b en=%b done=%b need %b 1 0", k, tx_out, tx_en, frame_done, pexp); end
                else passes++;
                step();
            end
            if (frame_done !== 1'b1 || tx_en !== 1'b0 || tx_out !== 1'b1)
                begin fails++; $display("FAIL parity_done%0d: done=%b en=%b tx=%b need 1 0 1", k, frame_done, tx_en, tx_out); end
            else passes++;
        end
        wait_idle();
    endtask

    task automatic test_data_hold;
        logic [DW-1:0] bits, cap;
        logic ld;
        wait_idle();
        send_collect(2, 8'h3C, bits, cap, ld);
        if (ld !== 1'b1 || cap !== 8'h3C) begin fails++; $display("FAIL hold_capture: load=%b data=%h need 1 3c", ld, cap); end else passes++;
        if (bits !== 8'h3C) begin fails++; $display("FAIL hold_bits: %h need 3c", bits); end else passes++;
        wait_idle();
    endtask

    task automatic test_valid_drop;
        wait_idle();
        req_valid = 4'b1000;
        #1;
        if (req_ready !== 4'b1000) begin fails++; $display("FAIL drop_ready: %b need 1000", req_ready); end else passes++;
        req_valid = '0;
        step();
        if (srl_load !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL drop_nostart: load=%b busy=%b need 0 0", srl_load, busy); end else passes++;
    endtask

    task automatic test_reset_mid_frame;
        wait_idle();
        req_data[7:0] = 8'h5A;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step(); step(); step(); step();
        if (tx_en !== 1'b1 || tx_out !== 1'b1) begin fails++; $display("FAIL mid_bit3: en=%b tx=%b need 1 1", tx_en, tx_out); end else passes++;
        rst = 1'b1;
        step();
        if ({tx_out, busy, frame_done, tx_en, srl_data, grant_id} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0})
            begin fails++; $display("FAIL mid_reset: tx=%b busy=%b done=%b en=%b data=%h gid=%0d need 1 0 0 0 00 0",
                                    tx_out, busy, frame_done, tx_en, srl_data, grant_id); end
        else passes++;
        rst = 1'b0;
        req_valid = 4'b0111; #1;
        if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_prio_0: %b need 0001", req_ready); end else passes++;
        req_valid = 4'b0110; #1;
        if (req_ready !== 4'b0010) begin fails++; $display("FAIL mid_prio_1: %b need 0010", req_ready); end else passes++;
        req_valid = 4'b0100; #1;
        if (req_ready !== 4'b0100) begin fails++; $display("FAIL mid_prio_2: %b need 0100", req_ready); end else passes++;
        step();
        req_valid = '0;
        if (srl_load !== 1'b1 || grant_id !== 2'd2) begin fails++; $display("FAIL mid_grant2: load=%b gid=%0d need 1 2", srl_load, grant_id); end else passes++;
        for (int i = 0; i < 5; i++) begin
            step();
            if (frame_done !== 1'b0) begin fails++; $display("FAIL mid_no_done%0d: %b need 0", i, frame_done); end else passes++;
        end
        wait_idle();
    endtask

    task automatic test_gap0_back_to_back;
        int loads [$];
        req_data_g[1*DW +: DW] = 8'h96;
        req_valid_g = 4'b0010;
        for (int c = 0; c < 3 * (DW + PAR + 2) + 4; c++) begin
            if (srl_load_g) begin
                loads.push_back(c);
                if (grant_id_g !== 2'd1 || srl_data_g !== 8'h96)
                    begin fails++; $display("FAIL g0_grant: gid=%0d data=%h need 1 96", grant_id_g, srl_data_g); end
                else passes++;
            end
            if (frame_done_g) begin
                if (busy_g !== 1'b0 || tx_en_g !== 1'b0) begin fails++; $display("FAIL g0_done_idle: busy=%b en=%b need 0 0", busy_g, tx_en_g); end
                else passes++;
            end
            step();
        end
        req_valid_g = '0;
        if (loads.size() < 3) begin fails++; $display("FAIL g0_load_count: %0d need >=3", loads.size()); end
        else begin
            passes++;
            for (int i = 1; i < 3; i++) begin
                if (loads[i] - loads[i-1] !== DW + PAR + 2)
                    begin fails++; $display("FAIL g0_spacing%0d: %0d need %0d", i, loads[i] - loads[i-1], DW + PAR + 2); end
                else passes++;
            end
        end
        step(); step();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_parity();
        test_data_hold();
        test_valid_drop();
        test_reset_mid_frame();
        test_gap0_back_to_back();
        $display("%0d/%0d checks passed", passes, passes + fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
